// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end between the CPU memory stage and a
// word-only data RAM. Adds byte/halfword loads (sign or zero extended),
// byte/halfword stores via read-modify-write, and misalignment detection.
//
// Ports
//   clock, reset_n           clock, asynchronous active-low reset
//   req/we/size/is_unsigned  CPU request (sampled only while ready=1)
//   addr, wdata              byte address, store data (sub-word in low bits)
//   ready                    high only in IDLE
//   done, err                one-cycle completion pulse, error flag with done
//   rdata                    load result, held until the next done
//   ram_addr/ram_we/ram_wdata  word-addressed RAM request
//   ram_rdata                RAM read data, READ_LATENCY cycles after ram_addr

// One byte lane of the read-modify-write merge.
module mau_byte_lane (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       sel,
  output logic [7:0] merged
);
  assign merged = sel ? new_byte : old_byte;
endmodule

module mem_access_unit #(
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam int       NUM_LANES = 4;
  localparam logic [2:0] LAST_RD = 3'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  // Only the request fields needed after accept; word-store data goes
  // straight into ram_wdata and the word address straight into ram_addr.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [1:0]  lo;
    logic [15:0] wdata_lo;
  } req_t;

  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       err_n;
  req_t       req_q, req_d;
  logic       accept, bad;
  logic       rd_last;

  logic [NUM_LANES-1:0][7:0] rd_lanes, new_lanes, merged;
  logic [NUM_LANES-1:0]      lane_en;
  logic [31:0]               load_val;
  logic [7:0]                sel_byte;
  logic [15:0]               sel_half;

  // Address bits above the RAM window are ignored (addresses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign req_d  = '{we: we, size: size, is_unsigned: is_unsigned,
                    lo: addr[1:0], wdata_lo: wdata[15:0]};
  assign accept = req && ready;
  assign bad    = (size == 2'b11) ||
                  (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00);
  assign rd_last = (state == RD) && (cnt == LAST_RD);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_n = '0;
          if (bad) begin
            state_n = DONE;
            err_n   = 1'b1;
          end else if (we && size == 2'b10) begin
            state_n = WR;
          end else begin
            state_n = RD;
          end
        end
      end
      RD: begin
        // RD spans READ_LATENCY+1 cycles so the word is valid in the last one.
        if (cnt == LAST_RD) state_n = req_q.we ? WR : DONE;
        else                cnt_n   = cnt + 3'd1;
      end
      WR:      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Load extraction (little-endian lanes)
  // ---------------------------------------------------------------------
  assign rd_lanes = ram_rdata;

  always_comb begin
    sel_byte = rd_lanes[req_q.lo];
    sel_half = req_q.lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (req_q.size)
      2'b00:   load_val = req_q.is_unsigned ? {24'b0, sel_byte}
                                            : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_val = req_q.is_unsigned ? {16'b0, sel_half}
                                            : {{16{sel_half[15]}}, sel_half};
      default: load_val = ram_rdata;
    endcase
  end

  // ---------------------------------------------------------------------
  // Store merge: only the addressed byte/half lanes take new data
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_en[g]   = (req_q.size == 2'b00) ? (req_q.lo == 2'(g))
                                                : (req_q.lo[1] == 1'(g >> 1));
    assign new_lanes[g] = (req_q.size == 2'b00) ? req_q.wdata_lo[7:0]
                                                : req_q.wdata_lo[8*(g%2) +: 8];
    mau_byte_lane u_lane (
      .old_byte (rd_lanes[g]),
      .new_byte (new_lanes[g]),
      .sel      (lane_en[g]),
      .merged   (merged[g])
    );
  end

  // ---------------------------------------------------------------------
  // State and registered outputs (decoded from the next state)
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ready  <= (state_n == IDLE);
      ram_we <= (state_n == WR);
      done   <= (state_n == DONE);
      err    <= err_n;

      if (accept) begin
        req_q <= req_d;
        if (bad) begin
          rdata <= '0;              // error completion reports zero data
        end else begin
          ram_addr <= addr[ADDR_W+1:2];
          if (we) ram_wdata <= wdata;
        end
      end

      if (rd_last) begin
        if (req_q.we) ram_wdata <= merged;
        else          rdata     <= load_val;
      end
    end
  end
endmodule
